matrix_frame_buf: RTL

Double-buffered 16×16 frame store that sits directly upstream of the LED-matrix column scanner. A producer loads a complete frame, column by column, into the back bank over a valid/ready handshake. The scanner fetches one 16-bit column per scan step from the front bank. The banks swap only at a frame boundary (after column 15 is fetched), so the display never shows a half-written frame.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_bank.sv | 36 +++
 rtl/matrix_frame_buf.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED-matrix double-buffered frame store.
package matrix_pkg;

  localparam int unsigned MATRIX_COLS = 16;
  localparam int unsigned MATRIX_ROWS = 16;
  localparam int unsigned COL_IDX_W   = 4;

  typedef logic [COL_IDX_W-1:0]   col_idx_t;
  typedef logic [MATRIX_ROWS-1:0] col_data_t;

  // Bank fill state: FILL accepts producer columns, PEND waits for a frame-end swap.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // One column write: target column and its row pixels.
  typedef struct packed {
    col_idx_t  col;
    col_data_t data;
  } col_wr_t;

  localparam col_idx_t LAST_COL = col_idx_t'(MATRIX_COLS - 1);

endpackage

// File: rtl/matrix_bank.sv
// One 16x16 column bank: synchronous write, registered read, cleared by reset.
module matrix_bank
  import matrix_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_we,
  input  col_wr_t   i_wr,
  input  logic      i_re,
  input  col_idx_t  i_raddr,
  output col_data_t o_rdata
);

  col_data_t r_mem [MATRIX_COLS];
  col_data_t r_rdata;

  // Column storage and read register; reset blanks the whole bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MATRIX_COLS; i++) begin
        r_mem[col_idx_t'(i)] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_wr.col] <= i_wr.data;
      end
      if (i_re) begin
        r_rdata <= r_mem[i_raddr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/matrix_frame_buf.sv
// Double-buffered 16x16 frame store feeding the LED column scanner.
// Producer fills the back bank; banks swap only after a column-15 fetch.
// Optional column scrolling of the displayed frame: define MATRIX_SCROLL_EN.
module matrix_frame_buf
  import matrix_pkg::*;
#(
  parameter int unsigned SCROLL_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_col,
  input  logic [15:0] wr_data,
  input  logic        wr_last,
  input  logic        rd_en,
  input  logic [3:0]  rd_col,
  output logic [15:0] rd_data,
  output logic        pending,
  output logic        swap_done
);

  if (SCROLL_FRAMES == 0 || SCROLL_FRAMES > 65535) begin : g_bad_cfg
    $error("SCROLL_FRAMES must be in 1..65535");
  end

  state_e    r_state;
  state_e    w_state_nxt;
  logic      r_front;
  logic      r_rd_sel;
  logic      r_swap_done;
  logic      w_wr_acc;
  logic      w_swap;
  logic      w_frame_end;
  col_idx_t  w_ofs;
  col_idx_t  w_rd_idx;
  col_wr_t   w_wr;
  col_data_t w_q0;
  col_data_t w_q1;

  assign w_frame_end = rd_en && (rd_col == LAST_COL);
  assign w_rd_idx    = rd_col + w_ofs;
  assign w_wr.col    = wr_col;
  assign w_wr.data   = wr_data;

  // Fill/pending sequencing: accept writes in FILL, swap from PEND on frame end.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_acc    = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_wr_acc = wr_valid;
        if (wr_valid && wr_last) begin
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_frame_end) begin
          w_swap      = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Front-bank pointer, read-bank select captured per fetch, and swap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front     <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= w_swap;
      if (rd_en) begin
        r_rd_sel <= r_front;
      end
      if (w_swap) begin
        r_front <= ~r_front;
      end
    end
  end

`ifdef MATRIX_SCROLL_EN
  localparam logic [15:0] SCROLL_LAST = 16'(SCROLL_FRAMES - 1);

  col_idx_t    r_ofs;
  logic [15:0] r_frm_cnt;

  // Scroll one column every SCROLL_FRAMES scans; a swap realigns new content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ofs     <= '0;
      r_frm_cnt <= '0;
    end else if (w_swap) begin
      r_ofs     <= '0;
      r_frm_cnt <= '0;
    end else if (w_frame_end) begin
      if (r_frm_cnt == SCROLL_LAST) begin
        r_frm_cnt <= '0;
        r_ofs     <= r_ofs + 4'd1;
      end else begin
        r_frm_cnt <= r_frm_cnt + 16'd1;
      end
    end
  end

  assign w_ofs = r_ofs;
`else
  assign w_ofs = '0;
`endif

  // Bank 0 and bank 1; writes go to whichever is not in front.
  matrix_bank u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_acc && r_front),
    .i_wr    (w_wr),
    .i_re    (rd_en),
    .i_raddr (w_rd_idx),
    .o_rdata (w_q0)
  );

  matrix_bank u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_acc && !r_front),
    .i_wr    (w_wr),
    .i_re    (rd_en),
    .i_raddr (w_rd_idx),
    .o_rdata (w_q1)
  );

  // Outputs are decodes/selects of registers only.
  assign rd_data   = r_rd_sel ? w_q1 : w_q0;
  assign wr_ready  = (r_state == ST_FILL);
  assign pending   = (r_state == ST_PEND);
  assign swap_done = r_swap_done;

endmodule
